mem_load_dump_ctrl: RTL and testbench

//  Sequencer driving the single-port file-buffer memory (read/write/addr/data_in/data_out).

---
 rtl/mem_load_dump_ctrl_if.sv | 31 +++
 rtl/mem_load_dump_ctrl.sv | 61 ++++++
 tb/tb_mem_load_dump_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_load_dump_ctrl_if.sv
// mem_load_dump_ctrl_if: input stream, output stream, dump control and memory port of the load/dump sequencer.
interface mem_load_dump_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  start_dump;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_ready;
   logic                  out_last;
   logic                  busy;
   logic [ADDR_WIDTH:0]   count;
   logic                  mem_read;
   logic                  mem_write;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   modport master (
      input  in_valid, in_data, start_dump, out_ready, mem_rdata,
      output in_ready, out_valid, out_data, out_last, busy, count,
             mem_read, mem_write, mem_addr, mem_wdata
   );
   modport slave (
      output in_valid, in_data, start_dump, out_ready, mem_rdata,
      input  in_ready, out_valid, out_data, out_last, busy, count,
             mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_load_dump_ctrl.sv
// mem_load_dump_ctrl: loads a word stream into memory from address 0, then dumps it back in order on request.
module mem_load_dump_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int MEM_SIZE   = 32
) (
   input logic clk,
   input logic rst_n,
   mem_load_dump_ctrl_if.master bus
);
   typedef enum logic [1:0] {S_LOAD, S_RD, S_OUT} state_t;
   localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(MEM_SIZE);
   localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH+1)'(1);
   state_t              state;
   logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
   logic                acc, last;
   always_comb begin
      acc           = rst_n && state == S_LOAD && bus.in_valid && wr_ptr < FULL;
      last          = rd_ptr == wr_ptr - ONE;
      bus.in_ready  = rst_n && state == S_LOAD && wr_ptr < FULL;
      bus.mem_write = acc;
      bus.mem_read  = rst_n && state == S_RD;
      bus.out_valid = rst_n && state == S_OUT;
      bus.out_last  = rst_n && state == S_OUT && last;
      bus.busy      = rst_n && state != S_LOAD;
      bus.count     = wr_ptr;
      bus.mem_addr  = state == S_LOAD ? wr_ptr[ADDR_WIDTH-1:0] : rd_ptr[ADDR_WIDTH-1:0];
      bus.mem_wdata = DATA_WIDTH'(bus.in_data);
      bus.out_data  = DATA_WIDTH'(bus.mem_rdata);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_LOAD;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (acc) wr_ptr <= wr_ptr + ONE;
               // a word accepted in the same cycle counts toward a non-empty dump
               if (bus.start_dump && (acc || wr_ptr != '0)) begin
                  state  <= S_RD;
                  rd_ptr <= '0;
               end
            end
            S_RD: state <= S_OUT;
            S_OUT: begin
               if (bus.out_ready && last) begin
                  state  <= S_LOAD;
                  wr_ptr <= '0;
                  rd_ptr <= '0;
               end else if (bus.out_ready) begin
                  state  <= S_RD;
                  rd_ptr <= rd_ptr + ONE;
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_load_dump_ctrl.sv
// tb_mem_load_dump_ctrl: directed and random stimulus against a queue-based model of the load/dump behaviour.
module tb_mem_load_dump_ctrl;
   logic clk = 0;
   logic rst_n = 0;
   int   total = 0;
   int   bad = 0;
   mem_load_dump_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus();
   mem_load_dump_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .MEM_SIZE(32)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   always #5 clk = ~clk;
   logic [7:0] mem [32];
   always @(posedge clk) begin
      if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr];
   end
   int  q[$];
   bit  dumping = 0;
   int  idx = 0;
   int  wait_cnt = 0;
   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic step();
      bit ov, rdy;
      @(negedge clk);
      if (!rst_n) begin
         check("rst_in_ready", bus.in_ready, 0);
         check("rst_out_valid", bus.out_valid, 0);
         check("rst_out_last", bus.out_last, 0);
         check("rst_mem_read", bus.mem_read, 0);
         check("rst_mem_write", bus.mem_write, 0);
         check("rst_busy", bus.busy, 0);
      end else begin
         rdy = !dumping && q.size() < 32;
         ov = dumping && wait_cnt == 0;
         check("in_ready", bus.in_ready, rdy);
         check("busy", bus.busy, dumping);
         check("count", bus.count, q.size());
         check("out_valid", bus.out_valid, ov);
         check("mem_read", bus.mem_read, dumping && wait_cnt == 1);
         check("mem_write", bus.mem_write, bus.in_valid && rdy);
         check("rd_wr_excl", bus.mem_read & bus.mem_write, 0);
         if (bus.in_valid && rdy) begin
            check("mem_addr", bus.mem_addr, q.size());
            check("mem_wdata", bus.mem_wdata, bus.in_data);
         end
         if (ov) begin
            check("out_data", bus.out_data, q[idx]);
            check("out_last", bus.out_last, idx == q.size() - 1);
         end else check("out_last_idle", bus.out_last, 0);
      end
      if (!rst_n) begin
         dumping = 0;
         q.delete();
      end else if (!dumping) begin
         if (bus.in_valid && q.size() < 32) q.push_back(bus.in_data);
         if (bus.start_dump && q.size() > 0) begin
            dumping = 1;
            idx = 0;
            wait_cnt = 1;
         end
      end else if (wait_cnt > 0) wait_cnt--;
      else if (bus.out_ready) begin
         if (idx == q.size() - 1) begin
            dumping = 0;
            q.delete();
         end else begin
            idx++;
            wait_cnt = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask
   task automatic cyc(input int n);
      repeat (n) step();
   endtask
   task automatic push(input logic [7:0] d);
      bus.in_valid = 1;
      bus.in_data = d;
      step();
      bus.in_valid = 0;
   endtask
   task automatic dump();
      bus.start_dump = 1;
      step();
      bus.start_dump = 0;
   endtask
   initial begin
      bus.in_valid = 0;
      bus.in_data = 0;
      bus.start_dump = 0;
      bus.out_ready = 0;
      cyc(2);
      rst_n = 1;
      check("reset_count", bus.count, 0);
      push(8'h11); push(8'h22); push(8'h33);
      dump();
      bus.out_ready = 1;
      cyc(8);
      for (int i = 0; i < 33; i++) push(8'(i));
      check("full_count", bus.count, 32);
      dump();
      cyc(70);
      for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
      dump();
      cyc(4);
      bus.out_ready = 0;
      cyc(6);
      bus.out_ready = 1;
      cyc(10);
      dump();
      cyc(4);
      push(8'h43);
      bus.in_valid = 1;
      bus.in_data = 8'h44;
      dump();
      bus.in_valid = 0;
      cyc(6);
      push(8'h61); push(8'h62); push(8'h63);
      dump();
      cyc(4);
      rst_n = 0;
      step();
      rst_n = 1;
      check("rst_mid_count", bus.count, 0);
      check("rst_mid_valid", bus.out_valid, 0);
      step();
      push(8'hAA);
      dump();
      cyc(4);
      for (int i = 0; i < 3000; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_data = 8'($urandom);
         bus.start_dump = $urandom_range(0, 15) == 0;
         bus.out_ready = $urandom_range(0, 3) != 0;
         rst_n = $urandom_range(0, 199) != 0;
         step();
      end
      rst_n = 1;
      bus.in_valid = 0;
      bus.start_dump = 0;
      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
